// File: rtl/rounding_shift_pipe.sv
// rounding_shift_pipe
// Two-stage pipelined unsigned divide by 2^k with a runtime shift amount, four
// rounding modes and saturation to OUT_WIDTH bits.
// S1 registers the shifted quotient and the round-up decision. S2 adds them and
// clamps the sum to the output range.
// Optional feature macro: ROUNDING_SAT_CNT_EN adds a 16-bit saturation event
// counter with a synchronous clear (ports sat_cnt_clr / sat_cnt).
//
// Handshake semantics (both sides): a beat transfers on a rising clk edge where
// valid && ready. A producer holds valid and its payload stable until the beat
// transfers. The ready chain is s2_ready = !out_valid || out_ready,
// s1_ready = !s1_valid || s2_ready, and in_ready = s1_ready. in_ready therefore
// depends combinationally on out_ready. There is no skid buffer.
module rounding_shift_pipe #(
    parameter int OUT_WIDTH = 32,
    parameter int SHIFT_W   = 3,
    parameter int IN_WIDTH  = OUT_WIDTH + (1 << SHIFT_W) - 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic [SHIFT_W-1:0]   shift,
    input  logic [1:0]           mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 sat
`ifdef ROUNDING_SAT_CNT_EN
    ,
    input  logic                 sat_cnt_clr,
    output logic [15:0]          sat_cnt
`endif
);

    localparam logic [SHIFT_W-1:0]  SHIFT_ONE = {{(SHIFT_W-1){1'b0}}, 1'b1};
    localparam logic [IN_WIDTH-1:0] IN_ONE    = {{(IN_WIDTH-1){1'b0}}, 1'b1};

    // Stage 1 state
    logic                 r_s1_valid;
    logic [IN_WIDTH-1:0]  r_s1_q;
    logic                 r_s1_inc;

    // Stage 2 (output) state
    logic                 r_out_valid;
    logic [OUT_WIDTH-1:0] r_dout;
    logic                 r_sat;

    // Combinational helpers
    logic                 w_s2_ready;
    logic                 w_s1_ready;
    logic [IN_WIDTH-1:0]  w_q;
    logic [IN_WIDTH-1:0]  w_mask;
    logic [IN_WIDTH-1:0]  w_rem;
    logic [IN_WIDTH-1:0]  w_half;
    logic                 w_inc;
    logic [IN_WIDTH:0]    w_sum;
    logic                 w_ovf;
    logic [OUT_WIDTH-1:0] w_s2_dout;

    // Ready chain: each stage can load when it is empty or is being emptied.
    always_comb begin
        w_s2_ready = !r_out_valid || out_ready;
        w_s1_ready = !r_s1_valid || w_s2_ready;
    end

    assign in_ready  = w_s1_ready;
    assign out_valid = r_out_valid;
    assign dout      = r_dout;
    assign sat       = r_sat;

    // Quotient, discarded remainder and round-up decision for the incoming beat.
    always_comb begin
        w_q    = din >> shift;
        w_mask = ~({IN_WIDTH{1'b1}} << shift);
        w_rem  = din & w_mask;
        w_half = '0;
        w_inc  = 1'b0;
        if (shift != '0) begin
            // Weight of the first discarded bit, i.e. the exact half point.
            w_half = IN_ONE << (shift - SHIFT_ONE);
            case (mode)
                2'b00:   w_inc = 1'b0;
                2'b01:   w_inc = (w_rem >= w_half);
                2'b10:   w_inc = (w_rem > w_half) || ((w_rem == w_half) && w_q[0]);
                2'b11:   w_inc = (w_rem != '0);
                default: w_inc = 1'b0;
            endcase
        end
    end

    // Apply the rounding increment one bit wider than the input and clamp to OUT_WIDTH.
    always_comb begin
        w_sum     = {1'b0, r_s1_q} + {{IN_WIDTH{1'b0}}, r_s1_inc};
        w_ovf     = |w_sum[IN_WIDTH:OUT_WIDTH];
        w_s2_dout = w_ovf ? {OUT_WIDTH{1'b1}} : w_sum[OUT_WIDTH-1:0];
    end

    // Stage 1 register: captures shift/mode results only on an input transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_q     <= '0;
            r_s1_inc   <= 1'b0;
        end else if (w_s1_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_q   <= w_q;
                r_s1_inc <= w_inc;
            end
        end
    end

    // Stage 2 register: holds dout/sat stable while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_sat       <= 1'b0;
        end else if (w_s2_ready) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_dout <= w_s2_dout;
                r_sat  <= w_ovf;
            end
        end
    end

`ifdef ROUNDING_SAT_CNT_EN
    logic [15:0] r_sat_cnt;

    // Count saturated results as they leave; clear overrides a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sat_cnt <= '0;
        end else if (sat_cnt_clr) begin
            r_sat_cnt <= '0;
        end else if (r_out_valid && out_ready && r_sat && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign sat_cnt = r_sat_cnt;
`endif

endmodule

// File: tb/tb_rounding_shift_pipe.sv
// tb_rounding_shift_pipe
// Directed bench for rounding_shift_pipe: a vector table of hand-computed
// results plus hand-written backpressure, mid-flight reset and (when
// ROUNDING_SAT_CNT_EN is defined) saturation counter sequences.
// Inputs change 1 time unit after a rising edge. Outputs are sampled on the falling edge.
module tb_rounding_shift_pipe;

    localparam int OUT_W   = 32;
    localparam int SHIFT_W = 3;
    localparam int IN_W    = OUT_W + (1 << SHIFT_W) - 1;
    localparam logic [IN_W-1:0] ALL1 = 39'h7F_FFFF_FFFF;

    typedef struct packed {
        logic [IN_W-1:0]    din;
        logic [SHIFT_W-1:0] shift;
        logic [1:0]         mode;
        logic [OUT_W-1:0]   dout;
        logic               sat;
    } vec_t;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    din;
    logic [SHIFT_W-1:0] shift;
    logic [1:0]         mode;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   dout;
    logic               sat;
`ifdef ROUNDING_SAT_CNT_EN
    logic               sat_cnt_clr;
    logic [15:0]        sat_cnt;
`endif

    logic [OUT_W:0] exp_q[$];
    int n_total;
    int n_pass;

    vec_t vecs[18];
    vec_t bp[6];

    rounding_shift_pipe #(
        .OUT_WIDTH(OUT_W),
        .SHIFT_W  (SHIFT_W)
    ) dut (
`ifdef ROUNDING_SAT_CNT_EN
        .sat_cnt_clr(sat_cnt_clr),
        .sat_cnt    (sat_cnt),
`endif
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din      (din),
        .shift    (shift),
        .mode     (mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dout     (dout),
        .sat      (sat)
    );

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // Scoreboard: every output transfer must match the head of the expected queue.
    always @(negedge clk) begin
        logic [OUT_W:0] e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {63'd0, out_valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result", {31'd0, sat, dout}, {31'd0, e});
            end
        end
    end

    // Driver: present one beat and hold it until accepted; scramble inputs afterwards.
    task automatic send(input vec_t v);
        int guard;
        @(posedge clk); #1;
        in_valid = 1'b1;
        din      = v.din;
        shift    = v.shift;
        mode     = v.mode;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("send_accept", {63'd0, in_ready}, 64'd1);
        exp_q.push_back({v.sat, v.dout});
        @(posedge clk); #1;
        in_valid = 1'b0;
        din      = {$urandom(), $urandom()};
        shift    = SHIFT_W'($urandom_range(0, 7));
        mode     = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_drain();
        for (int g = 0; g < 100 && exp_q.size() != 0; g++) @(negedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [OUT_W-1:0] held;
        int idx;

        n_total = 0;
        n_pass  = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        din       = '0;
        shift     = '0;
        mode      = '0;
        out_ready = 1'b1;
`ifdef ROUNDING_SAT_CNT_EN
        sat_cnt_clr = 1'b0;
`endif

        //                 din                shift mode   dout             sat
        vecs[0]  = '{39'd20,            3'd3, 2'b00, 32'd2,           1'b0};
        vecs[1]  = '{39'd20,            3'd3, 2'b01, 32'd3,           1'b0};
        vecs[2]  = '{39'd20,            3'd3, 2'b10, 32'd2,           1'b0};
        vecs[3]  = '{39'd20,            3'd3, 2'b11, 32'd3,           1'b0};
        vecs[4]  = '{39'd28,            3'd3, 2'b10, 32'd4,           1'b0};
        vecs[5]  = '{39'd0,             3'd0, 2'b11, 32'd0,           1'b0};
        vecs[6]  = '{39'd5,             3'd0, 2'b11, 32'd5,           1'b0};
        vecs[7]  = '{ALL1,              3'd7, 2'b01, 32'hFFFF_FFFF,   1'b1};
        vecs[8]  = '{ALL1,              3'd7, 2'b00, 32'hFFFF_FFFF,   1'b0};
        vecs[9]  = '{ALL1,              3'd0, 2'b00, 32'hFFFF_FFFF,   1'b1};
        vecs[10] = '{39'd10,            3'd2, 2'b10, 32'd2,           1'b0};
        vecs[11] = '{39'd14,            3'd2, 2'b10, 32'd4,           1'b0};
        vecs[12] = '{39'd13,            3'd2, 2'b11, 32'd4,           1'b0};
        vecs[13] = '{39'd13,            3'd2, 2'b01, 32'd3,           1'b0};
        vecs[14] = '{39'd3,             3'd1, 2'b10, 32'd2,           1'b0};
        vecs[15] = '{39'd5,             3'd1, 2'b01, 32'd3,           1'b0};
        vecs[16] = '{39'h7F_FFFF_FF80,  3'd7, 2'b11, 32'hFFFF_FFFF,   1'b0};
        vecs[17] = '{39'h7F_FFFF_FFC0,  3'd7, 2'b01, 32'hFFFF_FFFF,   1'b1};

        bp[0] = '{39'd100,  3'd2, 2'b00, 32'd25,  1'b0};
        bp[1] = '{39'd97,   3'd2, 2'b01, 32'd24,  1'b0};
        bp[2] = '{39'd102,  3'd2, 2'b01, 32'd26,  1'b0};
        bp[3] = '{39'd107,  3'd2, 2'b11, 32'd27,  1'b0};
        bp[4] = '{39'd90,   3'd2, 2'b10, 32'd22,  1'b0};
        bp[5] = '{39'd1000, 3'd3, 2'b00, 32'd125, 1'b0};

        // Reset block
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_dout",      {32'd0, dout},      64'd0);
        chk("rst_sat",       {63'd0, sat},       64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);

        // Table: one beat at a time, checking the two-cycle latency of each.
        for (int i = 0; i < 18; i++) begin
            send(vecs[i]);
            @(negedge clk);
            chk("lat_cycle1_low", {63'd0, out_valid}, 64'd0);
            @(negedge clk);
            chk("lat_cycle2_high", {63'd0, out_valid}, 64'd1);
        end
        wait_drain();

        // Backpressure: six back-to-back beats, consumer stalled for the first four cycles.
        idx = 0;
        held = '0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            out_ready = (c >= 4);
            if (idx < 6) begin
                in_valid = 1'b1;
                din      = bp[idx].din;
                shift    = bp[idx].shift;
                mode     = bp[idx].mode;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c == 2 || c == 3) begin
                chk("bp_in_ready_low",   {63'd0, in_ready},  64'd0);
                chk("bp_out_valid_held", {63'd0, out_valid}, 64'd1);
            end
            if (c == 2) begin
                held = dout;
                chk("bp_dout_first", {32'd0, dout}, 64'd25);
            end
            if (c == 3) begin
                chk("bp_dout_stable", {32'd0, dout}, {32'd0, held});
                chk("bp_accepts_before_release", 64'(idx), 64'd2);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({bp[idx].sat, bp[idx].dout});
                idx++;
            end
        end
        in_valid = 1'b0;
        chk("bp_all_accepted", 64'(idx), 64'd6);
        wait_drain();

        // Reset with both stages full: outputs clear immediately and nothing stale follows.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        din       = ALL1;
        shift     = 3'd0;
        mode      = 2'b00;
        @(posedge clk); #1;
        din       = 39'd20;
        shift     = 3'd3;
        mode      = 2'b01;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("rstmid_pre_out_valid", {63'd0, out_valid}, 64'd1);
        chk("rstmid_pre_in_ready",  {63'd0, in_ready},  64'd0);
        chk("rstmid_pre_sat",       {63'd0, sat},       64'd1);
        reset = 1'b1;
        #1;
        chk("rstmid_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rstmid_dout",      {32'd0, dout},      64'd0);
        chk("rstmid_sat",       {63'd0, sat},       64'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rstmid_in_ready", {63'd0, in_ready}, 64'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("rstmid_no_stale", {63'd0, out_valid}, 64'd0);
        end

`ifdef ROUNDING_SAT_CNT_EN
        // Saturation counter: three saturated transfers, then a clear coinciding with a fourth.
        chk("cnt_reset", {48'd0, sat_cnt}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            send(vecs[7]);
            wait_drain();
        end
        @(negedge clk);
        chk("cnt_three", {48'd0, sat_cnt}, 64'd3);
        send(vecs[7]);
        @(negedge clk);
        @(negedge clk);
        chk("cnt_clr_out_valid", {63'd0, out_valid}, 64'd1);
        sat_cnt_clr = 1'b1;
        @(posedge clk); #1;
        sat_cnt_clr = 1'b0;
        @(negedge clk);
        chk("cnt_clr_wins",     {48'd0, sat_cnt}, 64'd0);
        chk("cnt_clr_consumed", 64'(exp_q.size()), 64'd0);
        send(vecs[7]);
        wait_drain();
        @(negedge clk);
        chk("cnt_after_clr", {48'd0, sat_cnt}, 64'd1);
`endif

        // Final report
        wait_drain();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
